xor_mem_write_scheduler: RTL and testbench
==========================================

XOR_MEM_WRITE_SCHEDULER -- requirements
Module: xor_mem_write_scheduler

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, giving the memory address width; legal values are 2 or more.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, giving the write data width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid, input, 4 bits: requester i has a write pending on bit i.
REQ-006 SHALL have port req_addr, input, 4*ADDR_WIDTH bits: requester i address in slice [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-007 SHALL have port req_data, input, 4*DATA_WIDTH bits: requester i data in slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port req_ready, output, 4 bits: combinational grant; a transfer occurs when req_valid[i] and req_ready[i] are both 1.
REQ-009 SHALL have port clr_start, input, 1 bit: level-sampled request to zero the whole memory.
REQ-010 SHALL have port clr_busy, output, 1 bit: registered, 1 while a clear sweep is running.
REQ-011 SHALL have port clr_done, output, 1 bit: registered, one-cycle pulse when a sweep completes.
REQ-012 SHALL have ports enW (2 bits), wa1 and wa2 (ADDR_WIDTH each), w1 and w2 (DATA_WIDTH each), all outputs and all registered: the memory's two write ports.

Function
REQ-013 SHALL implement states IDLE and CLEAR, plus a registered round-robin pointer ptr in 0..3.
REQ-014 In IDLE with clr_start=0, SHALL scan requesters in order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - First valid requester is granted to port 1.
  - Next valid requester whose address differs from the port-1 address is granted to port 2.
REQ-015 SHALL grant at most 2 requesters per cycle; a valid requester whose address equals the port-1 address SHALL NOT be granted that cycle.
REQ-016 req_ready[i] SHALL be 1 only for granted requesters; it is 0 for all requesters in CLEAR and in any cycle where clr_start=1.
REQ-017 On the edge after a grant, SHALL drive the granted requester's address and data onto the port.
  - Port 1: enW[0]=1, wa1, w1.
  - Port 2: enW[1]=1, wa2, w2.
  - Latency is exactly 1 cycle.
  - An ungranted port SHALL have its enW bit 0 and hold its previous wa and w values.
REQ-018 After a cycle with grants, ptr SHALL become (index of last granted requester + 1) mod 4; otherwise ptr is unchanged.
REQ-019 clr_start=1 in IDLE SHALL move to CLEAR on the next edge, with clr_busy=1 and sweep counter cnt=0.
REQ-020 Each CLEAR cycle SHALL issue, on the following edge:
  - enW=2'b11, wa1=cnt, wa2=cnt+1, w1=0, w2=0;
  - then cnt+=2.
REQ-021 After the pair (2^ADDR_WIDTH-2, 2^ADDR_WIDTH-1) is issued, SHALL return to IDLE with clr_busy=0 and clr_done=1 for exactly one cycle.
  - A sweep takes 2^(ADDR_WIDTH-1) cycles.
REQ-022 clr_start SHALL be ignored while in CLEAR; clr_start still high on return to IDLE SHALL start a new sweep, with no arbitration in that cycle.
REQ-023 Pending requests SHALL NOT be lost or reordered by a clear; they are simply held (not granted) until IDLE.

Reset
REQ-024 On rst_n=0, SHALL immediately and asynchronously set:
  - state=IDLE, ptr=0, cnt=0;
  - enW=0, wa1=wa2=0, w1=w2=0;
  - clr_busy=0, clr_done=0.
REQ-025 rst_n asserted mid-sweep SHALL abort the sweep with no clr_done pulse; after release, the block is in IDLE with ptr=0.

Verification
REQ-026 Single request, reset release, req_valid=0001, addr 0x05, data 0xA5 -> req_ready=0001 that cycle; next cycle enW=01, wa1=0x05, w1=0xA5; ptr=1.
REQ-027 All four valid with distinct addresses, held 2 cycles, ptr=0 -> ready=0011 then 1100; ptr goes 2 then 0; enW=11 on both following cycles.
REQ-028 Requesters 0 and 1 both valid to addr 0x10, ptr=0 -> ready=0001 and enW=01, then ready=0010 and enW=01; the two never appear on ports in the same cycle.
REQ-029 clr_start pulse with ADDR_WIDTH=3 and requester 2 valid -> 4 CLEAR cycles issuing (0,1), (2,3), (4,5), (6,7) with w=0; req_ready=0 throughout; clr_done pulse; requester 2 granted in the first IDLE cycle.
REQ-030 rst_n driven low during cycle 2 of a sweep -> outputs 0 immediately; no clr_done; after release, req_valid=0100 -> granted to port 1.

Source files
------------

// File: rtl/xor_mem_write_scheduler.sv
// Schedules up to two requester writes per cycle onto a dual-write-port memory
// with round-robin fairness, and runs a full-memory clear sweep on request.
module xor_mem_write_scheduler #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [3:0]                req_valid,
   input  logic [4*ADDR_WIDTH-1:0]   req_addr,
   input  logic [4*DATA_WIDTH-1:0]   req_data,
   output logic [3:0]                req_ready,
   input  logic                      clr_start,
   output logic                      clr_busy,
   output logic                      clr_done,
   output logic [1:0]                enW,
   output logic [ADDR_WIDTH-1:0]     wa1,
   output logic [ADDR_WIDTH-1:0]     wa2,
   output logic [DATA_WIDTH-1:0]     w1,
   output logic [DATA_WIDTH-1:0]     w2,
   output logic                      dbg_state,
   output logic [1:0]                dbg_ptr
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] CLEAR = 1'b1;
   localparam logic [ADDR_WIDTH-1:0] LAST_PAIR = {{(ADDR_WIDTH-1){1'b1}}, 1'b0};

   logic [0:0]            state;
   logic [1:0]            ptr;
   logic [ADDR_WIDTH-1:0] cnt;

   logic                  arb_en;
   logic [1:0]            idx;
   logic                  g1_found, g2_found;
   logic [1:0]            g1_idx, g2_idx;
   logic [ADDR_WIDTH-1:0] g1_addr, g2_addr, cand_addr;
   logic [DATA_WIDTH-1:0] g1_data, g2_data;
   logic [3:0]            ready_c;

   // Handshake: requester i transfers on a rising edge where req_valid[i] and
   // req_ready[i] are both high; a requester keeps valid/addr/data stable until then.
   always_comb begin
      arb_en    = (state == IDLE) && !clr_start;
      idx       = 2'd0;
      cand_addr = '0;
      g1_found  = 1'b0;
      g2_found  = 1'b0;
      g1_idx    = 2'd0;
      g2_idx    = 2'd0;
      g1_addr   = '0;
      g2_addr   = '0;
      g1_data   = '0;
      g2_data   = '0;
      for (int k = 0; k < 4; k++) begin
         idx       = ptr + 2'(k);
         cand_addr = req_addr[int'(idx)*ADDR_WIDTH +: ADDR_WIDTH];
         if (req_valid[idx]) begin
            if (!g1_found) begin
               g1_found = 1'b1;
               g1_idx   = idx;
               g1_addr  = cand_addr;
               g1_data  = req_data[int'(idx)*DATA_WIDTH +: DATA_WIDTH];
            end else if (!g2_found && (cand_addr != g1_addr)) begin
               // same-address requesters wait so the two ports never collide
               g2_found = 1'b1;
               g2_idx   = idx;
               g2_addr  = cand_addr;
               g2_data  = req_data[int'(idx)*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end
      ready_c = 4'b0000;
      if (arb_en && g1_found) ready_c[g1_idx] = 1'b1;
      if (arb_en && g2_found) ready_c[g2_idx] = 1'b1;
   end

   assign req_ready = ready_c;
   assign dbg_state = state;
   assign dbg_ptr   = ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         ptr      <= 2'd0;
         cnt      <= '0;
         enW      <= 2'b00;
         wa1      <= '0;
         wa2      <= '0;
         w1       <= '0;
         w2       <= '0;
         clr_busy <= 1'b0;
         clr_done <= 1'b0;
      end else begin
         enW      <= 2'b00;
         clr_done <= 1'b0;
         if (state == CLEAR) begin
            enW <= 2'b11;
            wa1 <= cnt;
            wa2 <= cnt + ADDR_WIDTH'(1);
            w1  <= '0;
            w2  <= '0;
            cnt <= cnt + ADDR_WIDTH'(2);
            if (cnt == LAST_PAIR) begin
               state    <= IDLE;
               cnt      <= '0;
               clr_busy <= 1'b0;
               clr_done <= 1'b1;
            end
         end else if (clr_start) begin
            state    <= CLEAR;
            cnt      <= '0;
            clr_busy <= 1'b1;
         end else begin
            if (g1_found) begin
               enW[0] <= 1'b1;
               wa1    <= g1_addr;
               w1     <= g1_data;
            end
            if (g2_found) begin
               enW[1] <= 1'b1;
               wa2    <= g2_addr;
               w2     <= g2_data;
            end
            // fairness: next scan starts just after the last requester served
            if (g2_found)      ptr <= g2_idx + 2'd1;
            else if (g1_found) ptr <= g1_idx + 2'd1;
         end
      end
   end

endmodule

// File: tb/tb_xor_mem_write_scheduler.sv
// Randomized scoreboard bench for xor_mem_write_scheduler against a
// queue-based reference model of the arbitration and clear-sweep rules.
module tb_xor_mem_write_scheduler;
   localparam int AW = 5;
   localparam int DW = 8;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [3:0]      req_valid = '0;
   logic [4*AW-1:0] req_addr = '0;
   logic [4*DW-1:0] req_data = '0;
   logic [3:0]      req_ready;
   logic            clr_start = 1'b0;
   logic            clr_busy, clr_done;
   logic [1:0]      enW;
   logic [AW-1:0]   wa1, wa2;
   logic [DW-1:0]   w1, w2;
   logic            dbg_state;
   logic [1:0]      dbg_ptr;

   xor_mem_write_scheduler #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
      .req_data(req_data), .req_ready(req_ready), .clr_start(clr_start),
      .clr_busy(clr_busy), .clr_done(clr_done), .enW(enW), .wa1(wa1), .wa2(wa2),
      .w1(w1), .w2(w2), .dbg_state(dbg_state), .dbg_ptr(dbg_ptr)
   );

   // clock/reset block
   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]    en;
      logic [AW-1:0] wa1;
      logic [AW-1:0] wa2;
      logic [DW-1:0] w1;
      logic [DW-1:0] w2;
      logic          busy;
      logic          done;
      logic [1:0]    ptr;
      logic          st;
   } out_t;
   localparam int OW = $bits(out_t);

   logic [OW-1:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   // requester pending writes (held until granted)
   bit            pend[4];
   logic [AW-1:0] p_addr[4];
   logic [DW-1:0] p_data[4];
   bit            clr_req = 0;

   // reference model state
   int   m_ptr = 0;
   bit   m_clear = 0;
   int   m_cnt = 0;
   out_t m_last = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cycle();
      out_t nxt;
      logic [3:0] exp_rdy;
      int g1, g2, idx;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         req_valid[i] = pend[i];
         req_addr[i*AW +: AW] = p_addr[i];
         req_data[i*DW +: DW] = p_data[i];
      end
      clr_start = clr_req;
      #1;
      exp_rdy = 4'b0000;
      nxt = m_last;
      nxt.en = 2'b00;
      nxt.done = 1'b0;
      g1 = -1;
      g2 = -1;
      if (m_clear) begin
         nxt.en = 2'b11;
         nxt.wa1 = AW'(m_cnt);
         nxt.wa2 = AW'(m_cnt + 1);
         nxt.w1 = '0;
         nxt.w2 = '0;
         m_cnt += 2;
         if (m_cnt == (1 << AW)) begin
            m_clear = 0;
            nxt.busy = 1'b0;
            nxt.done = 1'b1;
         end else begin
            nxt.busy = 1'b1;
         end
      end else if (clr_req) begin
         m_clear = 1;
         m_cnt = 0;
         nxt.busy = 1'b1;
      end else begin
         for (int k = 0; k < 4; k++) begin
            idx = (m_ptr + k) % 4;
            if (pend[idx]) begin
               if (g1 < 0) g1 = idx;
               else if (g2 < 0 && p_addr[idx] != p_addr[g1]) g2 = idx;
            end
         end
         if (g1 >= 0) begin
            exp_rdy[g1] = 1'b1;
            nxt.en[0] = 1'b1;
            nxt.wa1 = p_addr[g1];
            nxt.w1 = p_data[g1];
            m_ptr = (g1 + 1) % 4;
         end
         if (g2 >= 0) begin
            exp_rdy[g2] = 1'b1;
            nxt.en[1] = 1'b1;
            nxt.wa2 = p_addr[g2];
            nxt.w2 = p_data[g2];
            m_ptr = (g2 + 1) % 4;
         end
         nxt.busy = 1'b0;
      end
      nxt.ptr = 2'(m_ptr);
      nxt.st = m_clear;
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      exp_q.push_back(nxt);
      m_last = nxt;
      if (g1 >= 0) pend[g1] = 0;
      if (g2 >= 0) pend[g2] = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_enW", 64'(enW), 64'(0));
      chk("rst_wa1", 64'(wa1), 64'(0));
      chk("rst_wa2", 64'(wa2), 64'(0));
      chk("rst_w1", 64'(w1), 64'(0));
      chk("rst_w2", 64'(w2), 64'(0));
      chk("rst_busy", 64'(clr_busy), 64'(0));
      chk("rst_done", 64'(clr_done), 64'(0));
      chk("rst_ptr", 64'(dbg_ptr), 64'(0));
      chk("rst_state", 64'(dbg_state), 64'(0));
      exp_q.delete();
      m_ptr = 0;
      m_clear = 0;
      m_cnt = 0;
      m_last = '0;
      for (int i = 0; i < 4; i++) pend[i] = 0;
      clr_req = 0;
      req_valid = '0;
      clr_start = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
      pend[i] = 1;
      p_addr[i] = a;
      p_data[i] = d;
   endtask

   // monitor: pops one expectation per edge and compares the registered outputs
   always @(posedge clk) begin
      out_t e;
      #1;
      if (rst_n && exp_q.size() > 0) begin
         e = out_t'(exp_q.pop_front());
         chk("enW", 64'(enW), 64'(e.en));
         if (e.en[0]) begin
            chk("wa1", 64'(wa1), 64'(e.wa1));
            chk("w1", 64'(w1), 64'(e.w1));
         end
         if (e.en[1]) begin
            chk("wa2", 64'(wa2), 64'(e.wa2));
            chk("w2", 64'(w2), 64'(e.w2));
         end
         if (e.en == 2'b00) begin
            chk("wa1_hold", 64'(wa1), 64'(e.wa1));
            chk("wa2_hold", 64'(wa2), 64'(e.wa2));
         end
         chk("clr_busy", 64'(clr_busy), 64'(e.busy));
         chk("clr_done", 64'(clr_done), 64'(e.done));
         chk("ptr", 64'(dbg_ptr), 64'(e.ptr));
         chk("state", 64'(dbg_state), 64'(e.st));
      end
   end

   initial begin
      for (int i = 0; i < 4; i++) begin
         pend[i] = 0;
         p_addr[i] = '0;
         p_data[i] = '0;
      end
      do_reset();

      // single request
      set_req(0, AW'(5), 8'hA5);
      cycle();
      cycle();

      // all four distinct from ptr=0
      do_reset();
      set_req(0, AW'(1), 8'h11);
      set_req(1, AW'(2), 8'h22);
      set_req(2, AW'(3), 8'h33);
      set_req(3, AW'(4), 8'h44);
      cycle();
      cycle();
      cycle();

      // same-address pair
      set_req(0, AW'(16), 8'h01);
      set_req(1, AW'(16), 8'h02);
      cycle();
      cycle();
      cycle();

      // clear sweep with a request held across it
      set_req(2, AW'(9), 8'h5C);
      clr_req = 1;
      cycle();
      clr_req = 0;
      repeat ((1 << (AW - 1)) + 3) cycle();

      // randomized traffic with occasional clears
      for (int n = 0; n < 1500; n++) begin
         for (int i = 0; i < 4; i++) begin
            if (!pend[i] && $urandom_range(0, 1) == 1)
               set_req(i, AW'($urandom_range(0, 7)), DW'($urandom));
         end
         if (clr_req) clr_req = ($urandom_range(0, 2) == 0);
         else         clr_req = ($urandom_range(0, 39) == 0);
         cycle();
      end
      clr_req = 0;
      for (int n = 0; n < 40 && m_clear; n++) cycle();

      // reset during the second cycle of a sweep
      clr_req = 1;
      cycle();
      clr_req = 0;
      cycle();
      do_reset();
      set_req(2, AW'(7), 8'hC3);
      cycle();
      cycle();
      cycle();

      repeat (3) @(posedge clk);
      #2;
      chk("queue_drained", 64'(exp_q.size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
